seq_det_ctrl: RTL
=================

// Module: seq_det_ctrl
// PURPOSE
//  Frame controller for a 1-bit serial sequence detector (e.g. the Moore "101" detector).
//  Accepts a DATA_W-bit word over a valid/ready handshake and clears the detector.
//  Streams the word into the detector LSB first, one bit per clk, then counts detector hits.
//  Returns a match count (and optional first-hit index) over a second valid/ready handshake.
// PARAMETERS
//  DATA_W   20  frame length in bits (>=3)
//  CNT_W    5   count/index width; must satisfy 2**CNT_W > DATA_W
//  DET_LAT  1   cycles from detector consuming a bit (posedge with det_xv=1) to det_y valid (1..4)
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        synchronous, active-low reset
//  in_valid   in   1        frame word offered
//  in_ready   out  1        controller idle, word accepted when in_valid&in_ready
//  data_in    in   DATA_W   frame word; bit 0 is sent first
//  det_clr    out  1        active-high clear to detector
//  det_x      out  1        serial bit to detector (registered)
//  det_xv     out  1        det_x carries a frame bit this cycle (registered)
//  det_y      in   1        detector output
//  out_valid  out  1        result available, held until out_ready
//  out_ready  in   1        result consumed when out_valid&out_ready
//  match_cnt  out  CNT_W    number of samples with det_y=1 in the frame
//  first_pos  out  CNT_W    [MATCH_POS_EN] bit index of first hit; 0 if none
//  no_match   out  1        [MATCH_POS_EN] 1 when match_cnt==0
// BEHAVIOUR
//  Reset (reset=0 at posedge): state=IDLE; det_clr=1; in_ready=0 that cycle.
//   All other outputs, counters and the valid pipe are 0; the frame in flight is discarded.
//  FSM (every transition takes one clk):
//   IDLE:  in_ready=1, det_clr=0; in_valid -> latch data_in to shift reg; clear bit_cnt, match_cnt,
//          sample idx, first flag -> CLEAR.
//   CLEAR: det_clr=1 for exactly one cycle -> SHIFT.
//   SHIFT: det_x<=sreg[0], det_xv<=1, sreg>>=1, bit_cnt++.
//          After DATA_W bits have been driven -> DRAIN, with det_xv<=0 and det_x<=0.
//   DRAIN: wait until the valid pipe is empty -> DONE.
//   DONE:  out_valid=1; match_cnt/first_pos stable; out_ready -> IDLE (in_ready=1 next cycle).
//  Sampling: det_xv is delayed by a DET_LAT-stage shift pipe.
//   When the pipe output is 1, det_y is sampled: match_cnt++ if det_y=1, and the sample index
//   increments (0..DATA_W-1). det_y is ignored at all other times.
//  Latency, in_valid accept to out_valid (out_ready already high): DATA_W+DET_LAT+3 clk (24 by default).
//  in_ready is 0 in CLEAR/SHIFT/DRAIN/DONE; in_valid there is ignored and the word is not latched.
//  out_ready outside DONE is ignored. In DONE with out_ready=1, the frame returns to IDLE;
//   no same-cycle accept of a new word.
//  match_cnt cannot exceed DATA_W, so no saturation is needed; CNT_W sizing is checked by an
//   elaboration-time assertion.
//  det_x and det_xv are 0 in every state except SHIFT.
// CONFIGURATION
//  MATCH_POS_EN defined:
//   first_pos and no_match ports exist. On the first sample with det_y=1, first_pos <= sample index.
//   no_match = (match_cnt==0) while out_valid.
//  MATCH_POS_EN undefined:
//   Both ports and the capture logic are absent; match_cnt behaviour is unchanged.
// TESTING (paired with a DET_LAT=1 Moore 101 detector, defaults)
//  T1 data_in=20'b10100101010010101010
//     -> match_cnt=6, first_pos=3, out_valid at accept+24.
//  T2 data_in=20'h55555
//     -> match_cnt=9, first_pos=2.
//  T3 data_in=20'h00000 and 20'hFFFFF
//     -> match_cnt=0, no_match=1, first_pos=0.
//  T4 out_ready held 0 for 10 cycles after DONE
//     -> out_valid, match_cnt stable; in_ready=0.
//     Raise out_ready -> IDLE; a second word is accepted the next cycle and gives the correct count.
//  T5 reset=0 for one cycle mid-SHIFT (bit 7)
//     -> next cycle IDLE, det_xv=0, det_clr=1, out_valid=0.
//     A new T1 frame then gives 6.
//  T6 in_valid pulsed during SHIFT with a different word
//     -> ignored; result equals the original frame's count.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: frame controller for a 1-bit serial sequence detector.
// Takes a DATA_W-bit word, clears the detector, and streams the word into it LSB first.
// It then counts the detector hits and returns the count over a valid/ready handshake.
// Optional feature macro MATCH_POS_EN: adds the first_pos and no_match result ports.
module seq_det_ctrl #(
   parameter int DATA_W  = 20,
   parameter int CNT_W   = 5,
   parameter int DET_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   output logic              det_clr,
   output logic              det_x,
   output logic              det_xv,
   input  logic              det_y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  match_cnt
`ifdef MATCH_POS_EN
   ,
   output logic [CNT_W-1:0]  first_pos,
   output logic              no_match
`endif
);

   // Counters share CNT_W, so the frame length must be representable.
   if (DATA_W < 3) begin : g_chk_data_w
      $error("seq_det_ctrl: DATA_W must be >= 3");
   end
   if ((2 ** CNT_W) <= DATA_W) begin : g_chk_cnt_w
      $error("seq_det_ctrl: CNT_W too small, need 2**CNT_W > DATA_W");
   end
   if ((DET_LAT < 1) || (DET_LAT > 4)) begin : g_chk_lat
      $error("seq_det_ctrl: DET_LAT must be in 1..4");
   end

   localparam logic [CNT_W-1:0] FRAME_BITS = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      SHIFT = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t             state;
   logic [DATA_W-1:0]  sreg;
   logic [CNT_W-1:0]   bit_cnt;
   logic [CNT_W-1:0]   samp_idx;
   // det_xv delayed by DET_LAT; the top stage marks a cycle in which det_y is valid
   logic [DET_LAT:1]   vld_pipe;
`ifdef MATCH_POS_EN
   logic               first_seen;
`endif

   // Control FSM, serializer, valid pipe and hit counter, all with registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         det_clr    <= 1'b1;
         det_x      <= 1'b0;
         det_xv     <= 1'b0;
         out_valid  <= 1'b0;
         sreg       <= '0;
         bit_cnt    <= '0;
         samp_idx   <= '0;
         match_cnt  <= '0;
         vld_pipe   <= '0;
`ifdef MATCH_POS_EN
         first_seen <= 1'b0;
         first_pos  <= '0;
         no_match   <= 1'b0;
`endif
      end else begin
         // Delay det_xv so sampling lines up with the detector's output latency
         vld_pipe[1] <= det_xv;
         for (int i = 2; i <= DET_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end

         // det_y is only meaningful when the delayed valid says so
         if (vld_pipe[DET_LAT]) begin
            if (det_y) begin
               match_cnt <= match_cnt + ONE;
`ifdef MATCH_POS_EN
               if (!first_seen) begin
                  first_pos  <= samp_idx;
                  first_seen <= 1'b1;
               end
`endif
            end
            samp_idx <= samp_idx + ONE;
         end

         case (state)
            IDLE: begin
               det_clr <= 1'b0;
               if (in_ready && in_valid) begin
                  sreg       <= data_in;
                  bit_cnt    <= '0;
                  samp_idx   <= '0;
                  match_cnt  <= '0;
`ifdef MATCH_POS_EN
                  first_seen <= 1'b0;
                  first_pos  <= '0;
`endif
                  in_ready   <= 1'b0;
                  det_clr    <= 1'b1;
                  state      <= CLEAR;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            CLEAR: begin
               det_clr <= 1'b0;
               state   <= SHIFT;
            end
            SHIFT: begin
               if (bit_cnt == FRAME_BITS) begin
                  det_x  <= 1'b0;
                  det_xv <= 1'b0;
                  state  <= DRAIN;
               end else begin
                  det_x   <= sreg[0];
                  det_xv  <= 1'b1;
                  sreg    <= sreg >> 1;
                  bit_cnt <= bit_cnt + ONE;
               end
            end
            DRAIN: begin
               // All in-flight detector samples have been counted once the pipe is empty
               if (!(|vld_pipe)) begin
                  out_valid <= 1'b1;
`ifdef MATCH_POS_EN
                  no_match  <= (match_cnt == '0);
`endif
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
`ifdef MATCH_POS_EN
                  no_match  <= 1'b0;
`endif
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
